ex_mc: RTL and testbench



---
 rtl/ex_pkg.sv | 35 +++
 rtl/ex_mc_div_seq.sv | 106 ++++++++++
 rtl/ex_mc.sv | 135 +++++++++++++
 tb/tb_ex_mc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared opcodes, result-class selects and divider state encoding for the execute stage.
package ex_pkg;

    localparam logic [7:0] ALU_NOP   = 8'b0000_0000;
    localparam logic [7:0] ALU_OR    = 8'b0010_0101;
    localparam logic [7:0] ALU_AND   = 8'b0010_0100;
    localparam logic [7:0] ALU_NOR   = 8'b0010_0111;
    localparam logic [7:0] ALU_XOR   = 8'b0010_0110;
    localparam logic [7:0] ALU_SLL   = 8'b0111_1100;
    localparam logic [7:0] ALU_SRL   = 8'b0000_0010;
    localparam logic [7:0] ALU_SRA   = 8'b0000_0011;
    localparam logic [7:0] ALU_ADD   = 8'b0010_0000;
    localparam logic [7:0] ALU_ADDU  = 8'b0010_0001;
    localparam logic [7:0] ALU_SUB   = 8'b0010_0010;
    localparam logic [7:0] ALU_SUBU  = 8'b0010_0011;
    localparam logic [7:0] ALU_SLT   = 8'b0010_1010;
    localparam logic [7:0] ALU_SLTU  = 8'b0010_1011;
    localparam logic [7:0] ALU_MULT  = 8'b0001_1000;
    localparam logic [7:0] ALU_MULTU = 8'b0001_1001;
    localparam logic [7:0] ALU_DIV   = 8'b0001_1010;
    localparam logic [7:0] ALU_DIVU  = 8'b0001_1011;

    localparam logic [2:0] SEL_NOP    = 3'b000;
    localparam logic [2:0] SEL_LOGIC  = 3'b001;
    localparam logic [2:0] SEL_SHIFT  = 3'b010;
    localparam logic [2:0] SEL_MULDIV = 3'b011;
    localparam logic [2:0] SEL_ARITH  = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/ex_mc_div_seq.sv
// Iterative restoring radix-2 divider: magnitudes are latched on start, one quotient bit per cycle.
//   state    | meaning
//   DIV_IDLE | waiting; a start latches operands and stalls this cycle
//   DIV_BUSY | shifting/subtracting, cnt counts down remaining iterations
//   DIV_DONE | quotient/remainder valid for exactly one cycle
module div_seq
    import ex_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         annul,
    input  logic         signed_op,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W);
    localparam logic [W-1:0] ONE = W'(1);

    div_state_t   state, state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0] rem_q, quo_q, dvs_q;
    logic         neg_q, neg_r, dz_q;
    logic         fire, dz_in, take;
    logic [W-1:0] dividend_mag, divisor_mag;
    logic [W:0]   shifted, trial;

    assign fire         = start && !annul;
    assign dz_in        = (divisor == '0);
    assign dividend_mag = (signed_op && dividend[W-1]) ? (~dividend + ONE) : dividend;
    assign divisor_mag  = (signed_op && divisor[W-1])  ? (~divisor + ONE)  : divisor;
    assign shifted      = {rem_q, quo_q[W-1]};
    assign trial        = shifted - {1'b0, dvs_q};
    assign take         = !trial[W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                DIV_IDLE: begin
                    if (fire) begin
                        rem_q <= '0;
                        // On divide-by-zero the raw dividend is kept so it can be returned as remainder
                        quo_q <= dz_in ? dividend : dividend_mag;
                        dvs_q <= divisor_mag;
                        neg_q <= signed_op && (dividend[W-1] ^ divisor[W-1]);
                        neg_r <= signed_op && dividend[W-1];
                        dz_q  <= dz_in;
                        cnt   <= CW'(W - 1);
                    end
                end
                DIV_BUSY: begin
                    if (!annul) begin
                        rem_q <= take ? trial[W-1:0] : shifted[W-1:0];
                        quo_q <= {quo_q[W-2:0], take};
                        cnt   <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (fire) state_nxt = dz_in ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: begin
                if (annul)            state_nxt = DIV_IDLE;
                else if (cnt == '0)   state_nxt = DIV_DONE;
            end
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            DIV_IDLE: busy = fire;
            DIV_BUSY: busy = !annul;
            DIV_DONE: done = !annul;
            default:  ;
        endcase
        quotient  = dz_q ? '1    : (neg_q ? (~quo_q + ONE) : quo_q);
        remainder = dz_q ? quo_q : (neg_r ? (~rem_q + ONE) : rem_q);
    end

endmodule

// File: rtl/ex_mc.sv
// Execute stage: combinational logic/shift/arith/multiply units plus a stalling sequential divider.
module ex_mc
    import ex_pkg::*;
#(
    parameter int W    = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [7:0]      aluop_i,
    input  logic [2:0]      alusel_i,
    input  logic [W-1:0]    reg1_i,
    input  logic [W-1:0]    reg2_i,
    input  logic [RA_W-1:0] wd_i,
    input  logic            wreg_i,
    output logic [RA_W-1:0] wd_o,
    output logic            wreg_o,
    output logic [W-1:0]    wdata_o,
    output logic            whilo_o,
    output logic [W-1:0]    hi_o,
    output logic [W-1:0]    lo_o,
    output logic            stallreq_o
);

    localparam int SW = $clog2(W);

    logic [SW-1:0]  shamt;
    logic [W-1:0]   logic_res, shift_res, arith_res;
    logic [W-1:0]   b_eff, sum;
    logic           sub_op, slt_s, slt_u, ovf;
    logic [2*W-1:0] mul_a, mul_b, prod;
    logic           is_mul, is_div;
    logic           div_busy, div_done;
    logic [W-1:0]   div_q, div_r;

    assign shamt = reg1_i[SW-1:0];

    always_comb begin
        case (aluop_i)
            ALU_OR:  logic_res = reg1_i | reg2_i;
            ALU_AND: logic_res = reg1_i & reg2_i;
            ALU_NOR: logic_res = ~(reg1_i | reg2_i);
            ALU_XOR: logic_res = reg1_i ^ reg2_i;
            default: logic_res = '0;
        endcase
    end

    always_comb begin
        case (aluop_i)
            ALU_SLL: shift_res = reg2_i << shamt;
            ALU_SRL: shift_res = reg2_i >> shamt;
            ALU_SRA: shift_res = $unsigned($signed(reg2_i) >>> shamt);
            default: shift_res = '0;
        endcase
    end

    // One adder serves add and subtract; overflow means the operand signs agreed but the sum's did not
    assign sub_op = (aluop_i == ALU_SUB) || (aluop_i == ALU_SUBU);
    assign b_eff  = sub_op ? ~reg2_i : reg2_i;
    assign sum    = reg1_i + b_eff + W'(sub_op);
    assign slt_s  = $signed(reg1_i) < $signed(reg2_i);
    assign slt_u  = reg1_i < reg2_i;
    assign ovf    = (alusel_i == SEL_ARITH)
                 && ((aluop_i == ALU_ADD) || (aluop_i == ALU_SUB))
                 && (reg1_i[W-1] == b_eff[W-1]) && (sum[W-1] != reg1_i[W-1]);

    always_comb begin
        case (aluop_i)
            ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU: arith_res = sum;
            ALU_SLT:  arith_res = W'(slt_s);
            ALU_SLTU: arith_res = W'(slt_u);
            default:  arith_res = '0;
        endcase
    end

    // Low 2W bits of the product of sign-extended operands equal the signed product
    assign mul_a = (aluop_i == ALU_MULT) ? {{W{reg1_i[W-1]}}, reg1_i} : {{W{1'b0}}, reg1_i};
    assign mul_b = (aluop_i == ALU_MULT) ? {{W{reg2_i[W-1]}}, reg2_i} : {{W{1'b0}}, reg2_i};
    assign prod  = mul_a * mul_b;

    assign is_mul = (alusel_i == SEL_MULDIV) && ((aluop_i == ALU_MULT) || (aluop_i == ALU_MULTU));
    assign is_div = (alusel_i == SEL_MULDIV) && ((aluop_i == ALU_DIV)  || (aluop_i == ALU_DIVU));

    div_seq #(.W(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div),
        .annul     (flush_i),
        .signed_op (aluop_i == ALU_DIV),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (rst) begin
            wd_o   = wd_i;
            wreg_o = wreg_i && !ovf && !flush_i;
            case (alusel_i)
                SEL_LOGIC: wdata_o = logic_res;
                SEL_SHIFT: wdata_o = shift_res;
                SEL_ARITH: wdata_o = arith_res;
                SEL_MULDIV: begin
                    if (is_mul) begin
                        whilo_o = 1'b1;
                        hi_o    = prod[2*W-1:W];
                        lo_o    = prod[W-1:0];
                    end else if (is_div) begin
                        whilo_o    = div_done;
                        hi_o       = div_r;
                        lo_o       = div_q;
                        stallreq_o = div_busy;
                    end
                end
                default: ;
            endcase
            if (flush_i) begin
                stallreq_o = 1'b0;
                whilo_o    = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_mc.sv
// Directed bench for ex_mc (W=32) with a per-cycle reference model and literal spot checks.
module tb_ex_mc;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    ex_mc #(.W(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: divide progress tracked as age within an operation of known length
    int          m_age = 0;
    int          m_len = 0;
    logic [31:0] m_a, m_b;
    logic        m_sgn;

    always @(negedge clk) begin
        logic [31:0] e_wdata, e_hi, e_lo;
        logic        e_whilo, e_stall, e_ovf, chk_wdata;
        longint      s;
        logic [63:0] p;
        e_wdata = 0; e_hi = 0; e_lo = 0;
        e_whilo = 0; e_stall = 0; e_ovf = 0; chk_wdata = 1;
        if (!rst) begin
            m_age = 0;
            chk("rst_wd", wd_o, 0);
            chk("rst_wreg", wreg_o, 0);
            chk("rst_hi", hi_o, 0);
            chk("rst_lo", lo_o, 0);
        end else begin
            if (!(alusel_i == SEL_MULDIV && (aluop_i == ALU_DIV || aluop_i == ALU_DIVU)))
                m_age = 0;
            case (alusel_i)
                SEL_LOGIC: begin
                    if (aluop_i == ALU_OR)       e_wdata = reg1_i | reg2_i;
                    else if (aluop_i == ALU_AND) e_wdata = reg1_i & reg2_i;
                    else if (aluop_i == ALU_NOR) e_wdata = ~(reg1_i | reg2_i);
                    else if (aluop_i == ALU_XOR) e_wdata = reg1_i ^ reg2_i;
                end
                SEL_SHIFT: begin
                    if (aluop_i == ALU_SLL)      e_wdata = reg2_i << reg1_i[4:0];
                    else if (aluop_i == ALU_SRL) e_wdata = reg2_i >> reg1_i[4:0];
                    else if (aluop_i == ALU_SRA) e_wdata = $signed(reg2_i) >>> reg1_i[4:0];
                end
                SEL_ARITH: begin
                    if (aluop_i == ALU_ADD || aluop_i == ALU_SUB) begin
                        if (aluop_i == ALU_ADD) s = longint'($signed(reg1_i)) + longint'($signed(reg2_i));
                        else                    s = longint'($signed(reg1_i)) - longint'($signed(reg2_i));
                        e_wdata = s[31:0];
                        e_ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                    end
                    else if (aluop_i == ALU_ADDU) e_wdata = reg1_i + reg2_i;
                    else if (aluop_i == ALU_SUBU) e_wdata = reg1_i - reg2_i;
                    else if (aluop_i == ALU_SLT)  e_wdata = ($signed(reg1_i) < $signed(reg2_i)) ? 1 : 0;
                    else if (aluop_i == ALU_SLTU) e_wdata = (reg1_i < reg2_i) ? 1 : 0;
                end
                SEL_MULDIV: begin
                    chk_wdata = 0;
                    if (aluop_i == ALU_MULT || aluop_i == ALU_MULTU) begin
                        if (aluop_i == ALU_MULT) p = longint'($signed(reg1_i)) * longint'($signed(reg2_i));
                        else                     p = {32'b0, reg1_i} * {32'b0, reg2_i};
                        e_whilo = !flush_i;
                        e_hi = p[63:32];
                        e_lo = p[31:0];
                    end else if (aluop_i == ALU_DIV || aluop_i == ALU_DIVU) begin
                        if (flush_i) begin
                            m_age = 0;
                        end else begin
                            if (m_age == 0) begin
                                m_a = reg1_i; m_b = reg2_i;
                                m_sgn = (aluop_i == ALU_DIV);
                                m_len = (reg2_i == 0) ? 2 : 34;
                                m_age = 1;
                            end
                            e_stall = (m_age < m_len);
                            e_whilo = (m_age == m_len);
                            if (e_whilo) begin
                                if (m_b == 0) begin
                                    e_lo = 32'hFFFF_FFFF; e_hi = m_a;
                                end else if (m_sgn) begin
                                    e_lo = $signed(m_a) / $signed(m_b);
                                    e_hi = $signed(m_a) % $signed(m_b);
                                end else begin
                                    e_lo = m_a / m_b;
                                    e_hi = m_a % m_b;
                                end
                            end
                            m_age = (m_age == m_len) ? 0 : m_age + 1;
                        end
                    end
                end
                default: ;
            endcase
            chk("m_wd", wd_o, wd_i);
            chk("m_wreg", wreg_o, wreg_i && !e_ovf && !flush_i);
            if (e_whilo) begin
                chk("m_hi", hi_o, e_hi);
                chk("m_lo", lo_o, e_lo);
            end
        end
        if (chk_wdata) chk("m_wdata", wdata_o, e_wdata);
        chk("m_whilo", whilo_o, e_whilo);
        chk("m_stall", stallreq_o, e_stall);
    end

    int wd_seq = 1;

    task automatic op(input logic [7:0] opc, input logic [2:0] sel,
                      input logic [31:0] a, input logic [31:0] b, input logic wr);
        @(posedge clk); #1;
        flush_i  = 1'b0;
        aluop_i  = opc;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wreg_i   = wr;
        wd_i     = 5'(wd_seq);
        wd_seq++;
    endtask

    task automatic run_div(input string name, input logic [7:0] opc, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int exp_stall);
        int n;
        bit fin;
        n = 0;
        fin = 0;
        op(opc, SEL_MULDIV, a, b, 1'b0);
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            if (stallreq_o) n++;
            else fin = 1;
        end
        chk({name, "_finished"}, fin, 1);
        chk({name, "_stalls"}, n, exp_stall);
        chk({name, "_whilo"}, whilo_o, 1);
        chk({name, "_lo"}, lo_o, exp_lo);
        chk({name, "_hi"}, hi_o, exp_hi);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush_i = 1'b0;
        aluop_i = ALU_OR; alusel_i = SEL_LOGIC;
        reg1_i = 32'hFFFF_FFFF; reg2_i = 32'h1234_5678;
        wd_i = 5'd7; wreg_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_wd_lit", wd_o, 0);
        @(posedge clk); #1 rst = 1'b1;

        op(ALU_OR, SEL_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 1);
        @(negedge clk); chk("or_lit", wdata_o, 32'hF0F0_0F0F);
        op(ALU_AND, SEL_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 1);
        @(negedge clk); chk("and_lit", wdata_o, 32'h0F00_0F00);
        op(ALU_NOR, SEL_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 1);
        op(ALU_XOR, SEL_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 1);
        op(ALU_ADD, SEL_LOGIC, 32'h1, 32'h2, 1);
        @(negedge clk); chk("logic_badop_lit", wdata_o, 0);
        op(ALU_SLL, SEL_SHIFT, 32'd31, 32'h0000_0003, 1);
        op(ALU_SRL, SEL_SHIFT, 32'd36, 32'h8000_0000, 1);
        @(negedge clk); chk("srl_amt_mod_lit", wdata_o, 32'h0800_0000);
        op(ALU_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000, 1);
        @(negedge clk); chk("sra_lit", wdata_o, 32'hF800_0000);
        op(ALU_SRA, SEL_SHIFT, 32'd8, 32'h7000_0000, 1);
        op(ALU_ADD, SEL_ARITH, 32'h7FFF_FFFF, 32'h1, 1);
        @(negedge clk); chk("add_ovf_wreg_lit", wreg_o, 0); chk("add_ovf_data_lit", wdata_o, 32'h8000_0000);
        op(ALU_ADDU, SEL_ARITH, 32'h7FFF_FFFF, 32'h1, 1);
        @(negedge clk); chk("addu_wreg_lit", wreg_o, 1);
        op(ALU_ADD, SEL_ARITH, 32'hFFFF_FFFE, 32'h5, 1);
        op(ALU_SUB, SEL_ARITH, 32'h8000_0000, 32'h1, 1);
        @(negedge clk); chk("sub_ovf_wreg_lit", wreg_o, 0);
        op(ALU_SUB, SEL_ARITH, 32'd10, 32'd3, 1);
        op(ALU_SUBU, SEL_ARITH, 32'd3, 32'd10, 1);
        op(ALU_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 1);
        @(negedge clk); chk("slt_lit", wdata_o, 1);
        op(ALU_SLTU, SEL_ARITH, 32'd1, 32'hFFFF_FFFF, 1);
        @(negedge clk); chk("sltu_lit", wdata_o, 1);
        op(ALU_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 1);
        op(ALU_MULT, SEL_MULDIV, 32'hFFFF_FFFF, 32'd2, 0);
        @(negedge clk);
        chk("mult_hi_lit", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo_lit", lo_o, 32'hFFFF_FFFE);
        chk("mult_whilo_lit", whilo_o, 1);
        op(ALU_MULTU, SEL_MULDIV, 32'hFFFF_FFFF, 32'd2, 0);
        @(negedge clk); chk("multu_hi_lit", hi_o, 32'h0000_0001);
        op(ALU_MULT, SEL_MULDIV, 32'h8000_0000, 32'h8000_0000, 0);
        op(ALU_OR, 3'b111, 32'h1234, 32'h5678, 1);
        @(negedge clk); chk("badsel_wdata_lit", wdata_o, 0); chk("badsel_whilo_lit", whilo_o, 0);
        op(ALU_NOP, SEL_NOP, 32'h0, 32'h0, 0);

        run_div("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div("div_100_m7", ALU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 33);
        run_div("divu_big", ALU_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 33);
        run_div("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
        run_div("div_m20_0", ALU_DIV, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1);
        op(ALU_NOP, SEL_NOP, 32'h0, 32'h0, 0);

        // Flush in cycle 10 of a divide
        op(ALU_DIVU, SEL_MULDIV, 32'd1000, 32'd3, 1);
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        chk("flush_stall_lit", stallreq_o, 0);
        chk("flush_whilo_lit", whilo_o, 0);
        chk("flush_wreg_lit", wreg_o, 0);
        run_div("after_flush", ALU_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // Reset mid-divide
        op(ALU_DIVU, SEL_MULDIV, 32'd1000, 32'd3, 1);
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_stall_lit", stallreq_o, 0);
        chk("rstmid_whilo_lit", whilo_o, 0);
        chk("rstmid_lo_lit", lo_o, 0);
        chk("rstmid_wreg_lit", wreg_o, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        aluop_i = ALU_NOP; alusel_i = SEL_NOP;
        run_div("after_rst", ALU_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 33);
        op(ALU_NOP, SEL_NOP, 32'h0, 32'h0, 0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
